// File: rtl/usqrt_arb.sv
// usqrt_arb: round-robin sharing of one pipelined fixed-point square root among N requesters.
// Optional build macro USQRT_ARB_NEG_CHECK_EN adds sticky per-requester err_neg flags and zeroes
// the results of operands whose MSB is set.

// usqrt: restoring digit-by-digit square root, one root bit per stage, latency WIDTH-(WIDTH-SCALE)/2
module usqrt #(
  parameter int WIDTH = 20,
  parameter int SCALE = 12
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] f
);
  localparam int R  = WIDTH - (WIDTH - SCALE) / 2;
  localparam int D  = 2 * R;
  localparam int RW = R + 3;
  localparam int SW = RW + R + D;

  logic [SW-1:0] st [R];

  // one radicand bit pair: remainder, partial root and remaining radicand advance together
  function automatic logic [SW-1:0] step(input logic [SW-1:0] x);
    logic [RW-1:0] rem, cur, trial;
    logic [R-1:0]  rt;
    logic [D-1:0]  rad;
    logic          ge;
    {rem, rt, rad} = x;
    cur   = (rem << 2) | RW'(rad[D-1 -: 2]);
    trial = RW'({rt, 2'b01});
    ge    = cur >= trial;
    return {ge ? cur - trial : cur, (rt << 1) | R'(ge), rad << 2};
  endfunction

  // radicand is a scaled up by 2^SCALE so the integer root carries SCALE fraction bits
  always_ff @(posedge clk) begin
    st[0] <= step({RW'(0), R'(0), D'(a) << SCALE});
    for (int s = 1; s < R; s++) st[s] <= step(st[s-1]);
  end

  assign f = WIDTH'(st[R-1][D +: R]);
endmodule

module usqrt_arb #(
  parameter int N     = 4,
  parameter int WIDTH = 20,
  parameter int SCALE = 12,
  parameter int LAT   = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*WIDTH-1:0] req_a,
  output logic [N-1:0]       rsp_valid,
  input  logic [N-1:0]       rsp_ready,
  output logic [N*WIDTH-1:0] rsp_f
`ifdef USQRT_ARB_NEG_CHECK_EN
  ,
  output logic [N-1:0]       err_neg
`endif
);
  localparam int PW = $clog2(N);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef USQRT_ARB_NEG_CHECK_EN
  localparam int TW = PW + 1;
`else
  localparam int TW = PW;
`endif

  if (LAT != WIDTH - (WIDTH - SCALE) / 2) begin : g_lat_chk
    $error("usqrt_arb: LAT must equal WIDTH-(WIDTH-SCALE)/2");
  end
  if (N < 2 || N > 16 || DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_chk
    $error("usqrt_arb: N must be 2..16 and DEPTH a power of two");
  end

  logic                run;
  logic [PW-1:0]       ptr, win;
  logic                any;
  logic [N-1:0]        elig, push, pop;
  logic [WIDTH-1:0]    win_a, a_q, f;
  logic                vld_q;
  logic [TW-1:0]       tag_d, tag_q;
  logic [LAT-1:0]      vld_p;
  logic [TW-1:0]       tag_p [LAT];
  logic                wb_vld;
  logic [PW-1:0]       wb_tag;
  logic [WIDTH-1:0]    wb_f;
  logic [CW-1:0]       cnt  [N];
  logic [CW-1:0]       fcnt [N];
  logic [AW-1:0]       wp   [N];
  logic [AW-1:0]       rp   [N];
  logic [WIDTH-1:0]    mem  [N][DEPTH];

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % N);
  endfunction

  function automatic logic [AW-1:0] nxt_p(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // FIFO status, credit eligibility and head presentation per requester
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rsp_valid[i]             = fcnt[i] != '0;
      pop[i]                   = rsp_valid[i] && rsp_ready[i];
      push[i]                  = wb_vld && wb_tag == PW'(i);
      rsp_f[i*WIDTH +: WIDTH]  = rsp_valid[i] ? mem[i][rp[i]] : '0;
      elig[i]                  = run && req_valid[i] && cnt[i] < CW'(DEPTH);
    end
  end

  // round-robin search starting at ptr; full-credit requesters are simply skipped
  always_comb begin
    req_ready = '0;
    win       = '0;
    any       = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && elig[wrap(int'(ptr) + k)]) begin
        any                              = 1'b1;
        win                              = wrap(int'(ptr) + k);
        req_ready[wrap(int'(ptr) + k)]   = 1'b1;
      end
    end
    win_a = req_a[win*WIDTH +: WIDTH];
  end

`ifdef USQRT_ARB_NEG_CHECK_EN
  assign tag_d = {win_a[WIDTH-1], win};
`else
  assign tag_d = win;
`endif

  // issue register and round-robin pointer; run holds grants off until the first edge after release
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      run   <= 1'b0;
      ptr   <= '0;
      a_q   <= '0;
      vld_q <= 1'b0;
      tag_q <= '0;
    end else begin
      run   <= 1'b1;
      a_q   <= any ? win_a : '0;
      vld_q <= any;
      tag_q <= any ? tag_d : '0;
      if (any) ptr <= wrap(int'(win) + 1);
    end
  end

  usqrt #(.WIDTH(WIDTH), .SCALE(SCALE)) u_sqrt (.clk(clk), .a(a_q), .f(f));

  // tag pipe shadowing the sqrt stages so the owner arrives alongside its result
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      vld_p <= '0;
      for (int s = 0; s < LAT; s++) tag_p[s] <= '0;
    end else begin
      vld_p    <= {vld_p[LAT-2:0], vld_q};
      tag_p[0] <= tag_q;
      for (int s = 1; s < LAT; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  // writeback register between the sqrt output and the result FIFOs
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wb_vld <= 1'b0;
      wb_tag <= '0;
      wb_f   <= '0;
    end else begin
      wb_vld <= vld_p[LAT-1];
      wb_tag <= tag_p[LAT-1][PW-1:0];
`ifdef USQRT_ARB_NEG_CHECK_EN
      wb_f   <= tag_p[LAT-1][PW] ? '0 : f;
`else
      wb_f   <= f;
`endif
    end
  end

  // FIFO pointers, occupancy and credits; a credit covers an op from grant until its result pops
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < N; i++) begin
        cnt[i]  <= '0;
        fcnt[i] <= '0;
        wp[i]   <= '0;
        rp[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) wp[i] <= nxt_p(wp[i]);
        if (pop[i]) rp[i] <= nxt_p(rp[i]);
        fcnt[i] <= fcnt[i] + CW'(push[i]) - CW'(pop[i]);
        cnt[i]  <= cnt[i] + CW'(req_ready[i]) - CW'(pop[i]);
      end
    end
  end

  // result storage; contents are only visible while the FIFO is non-empty
  always_ff @(posedge clk) begin
    if (wb_vld) mem[wb_tag][wp[wb_tag]] <= wb_f;
  end

`ifdef USQRT_ARB_NEG_CHECK_EN
  // sticky flag for any accepted operand with its sign bit set
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) err_neg <= '0;
    else if (any && win_a[WIDTH-1]) err_neg[win] <= 1'b1;
  end
`endif

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_l)
    wb_vld |-> fcnt[wb_tag] != CW'(DEPTH));
endmodule

// File: tb/tb_usqrt_arb.sv
// tb_usqrt_arb: randomized and directed checks of usqrt_arb against a queue-based reference model
module tb_usqrt_arb;
  localparam int N = 4, W = 20, S = 12, LAT = 16, DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset_l = 1'b0;
  logic [N-1:0]   req_valid = '0, rsp_ready = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [N*W-1:0] rsp_f;
`ifdef USQRT_ARB_NEG_CHECK_EN
  logic [N-1:0]   err_neg;
`endif

  usqrt_arb #(.N(N), .WIDTH(W), .SCALE(S), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_l(reset_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f)
`ifdef USQRT_ARB_NEG_CHECK_EN
    , .err_neg(err_neg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int req; int left; logic [W-1:0] val;} fl_t;

  int             n_checks = 0, n_fail = 0;
  int             ptr_m, exp_w;
  int             cnt_m [N];
  logic [W-1:0]   fifo_m [N][$];
  fl_t            fl_q [$];
  logic [N-1:0]   err_m, exp_gnt, exp_valid;
  logic [W-1:0]   exp_f [N];

  function automatic logic [W-1:0] ref_sqrt(input logic [W-1:0] a);
    longint v = longint'(a) << S;
    longint r = longint'($floor($sqrt(real'(v))));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return W'(r);
  endfunction

  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a);
`ifdef USQRT_ARB_NEG_CHECK_EN
    if (a[W-1]) return '0;
`endif
    return ref_sqrt(a);
  endfunction

  task automatic model_reset();
    ptr_m = 0;
    err_m = '0;
    fl_q.delete();
    for (int i = 0; i < N; i++) begin
      cnt_m[i] = 0;
      fifo_m[i].delete();
    end
  endtask

  task automatic eval();
    exp_gnt = '0;
    exp_w = 0;
    for (int k = 0; k < N; k++) begin
      int i = (ptr_m + k) % N;
      if (exp_gnt == '0 && req_valid[i] && cnt_m[i] < DEPTH) begin
        exp_gnt[i] = 1'b1;
        exp_w = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_valid[i] = fifo_m[i].size() > 0;
      exp_f[i] = exp_valid[i] ? fifo_m[i][0] : '0;
    end
  endtask

  task automatic commit();
    logic [W-1:0] a;
    for (int i = 0; i < N; i++)
      if (exp_valid[i] && rsp_ready[i]) begin
        void'(fifo_m[i].pop_front());
        cnt_m[i]--;
      end
    for (int j = 0; j < fl_q.size(); j++) fl_q[j].left = fl_q[j].left - 1;
    while (fl_q.size() > 0 && fl_q[0].left == 0) begin
      fifo_m[fl_q[0].req].push_back(fl_q[0].val);
      void'(fl_q.pop_front());
    end
    if (exp_gnt != '0) begin
      a = req_a[exp_w*W +: W];
      fl_q.push_back('{exp_w, LAT + 2, ref_res(a)});
      cnt_m[exp_w]++;
      ptr_m = (exp_w + 1) % N;
      if (a[W-1]) err_m[exp_w] = 1'b1;
    end
  endtask

  task automatic settle();
    #1;
    eval();
  endtask

  task automatic tick();
    #1;
    eval();
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    @(posedge clk);
    @(negedge clk);
    reset_l = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic rand_ops(input bit allow_neg);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'($urandom);
      if (!allow_neg) req_a[i*W + W - 1] = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = '1;
    rsp_ready = '1;
    rand_ops(1'b1);
    #1;
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_f !== '0) begin n_fail++; $display("FAIL reset_f got=%h exp=0", rsp_f); end
`ifdef USQRT_ARB_NEG_CHECK_EN
    n_checks++; if (err_neg !== '0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_neg); end
`endif
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = '1;
    req_a = '0;
    req_a[W-1:0] = 20'h04000;
    req_valid = 4'b0001;
    settle();
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 18; k++) begin
      settle();
      n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL single_early k=%0d got=%b exp=0", k, rsp_valid); end
      tick();
    end
    settle();
    n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid got=%b exp=0001", rsp_valid); end
    n_checks++; if (rsp_f[W-1:0] !== 20'h02000) begin n_fail++; $display("FAIL single_f got=%h exp=02000", rsp_f[W-1:0]); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] ops [N];
    logic [W-1:0] want [N];
    int seen [N];
    ops = '{20'h01000, 20'h02000, 20'h04000, 20'h09000};
    want = '{20'h01000, 20'h016A0, 20'h02000, 20'h03000};
    do_reset();
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ops[i];
      seen[i] = 0;
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      settle();
      n_checks++; if (req_ready !== N'(1 << (k % N))) begin n_fail++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, N'(1 << (k % N))); end
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 30; k++) begin
      settle();
      n_checks++; if (rsp_valid !== exp_valid) begin n_fail++; $display("FAIL rr_valid k=%0d got=%b exp=%b", k, rsp_valid, exp_valid); end
      for (int i = 0; i < N; i++)
        if (rsp_valid[i]) begin
          seen[i]++;
          n_checks++; if (rsp_f[i*W +: W] !== want[i]) begin n_fail++; $display("FAIL rr_f req=%0d got=%h exp=%h", i, rsp_f[i*W +: W], want[i]); end
        end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (seen[i] != 2) begin n_fail++; $display("FAIL rr_count req=%0d got=%0d exp=2", i, seen[i]); end
    end
  endtask

  task automatic test_back_pressure();
    int acc1 = 0, others = 0, pops1 = 0, acc_after = 0;
    do_reset();
    rsp_ready = 4'b1101;
    req_valid = '1;
    for (int k = 0; k < 40; k++) begin
      rand_ops(1'b0);
      settle();
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL bp_grant k=%0d got=%b exp=%b", k, req_ready, exp_gnt); end
      if (req_ready[1]) acc1++;
      else if (k >= 20 && req_ready != '0) others++;
      tick();
    end
    n_checks++; if (acc1 != DEPTH) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=%0d", acc1, DEPTH); end
    n_checks++; if (others == 0) begin n_fail++; $display("FAIL bp_others got=0 exp=nonzero"); end
    settle();
    n_checks++; if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_blocked got=%b exp=0", req_ready[1]); end
    rsp_ready = '1;
    req_valid = 4'b0010;
    for (int k = 0; k < 30; k++) begin
      rand_ops(1'b0);
      settle();
      n_checks++; if (req_ready !== exp_gnt || rsp_valid !== exp_valid) begin n_fail++; $display("FAIL bp_drain_ctl k=%0d got=%b/%b exp=%b/%b", k, req_ready, rsp_valid, exp_gnt, exp_valid); end
      if (rsp_valid[1]) begin
        if (pops1 < DEPTH && req_ready[1]) acc_after++;
        pops1++;
        n_checks++; if (rsp_f[W +: W] !== exp_f[1]) begin n_fail++; $display("FAIL bp_drain_f k=%0d got=%h exp=%h", k, rsp_f[W +: W], exp_f[1]); end
      end
      tick();
    end
    n_checks++; if (pops1 < DEPTH) begin n_fail++; $display("FAIL bp_drained got=%0d exp>=%0d", pops1, DEPTH); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) rsp_ready[i] = $urandom_range(3) != 0;
      rand_ops(1'b1);
      settle();
      n_checks++; if (req_ready !== exp_gnt) begin n_fail++; $display("FAIL rnd_grant k=%0d got=%b exp=%b", k, req_ready, exp_gnt); end
      n_checks++; if (rsp_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid k=%0d got=%b exp=%b", k, rsp_valid, exp_valid); end
      for (int i = 0; i < N; i++)
        if (exp_valid[i]) begin
          n_checks++; if (rsp_f[i*W +: W] !== exp_f[i]) begin n_fail++; $display("FAIL rnd_f k=%0d req=%0d got=%h exp=%h", k, i, rsp_f[i*W +: W], exp_f[i]); end
        end
`ifdef USQRT_ARB_NEG_CHECK_EN
      n_checks++; if (err_neg !== err_m) begin n_fail++; $display("FAIL rnd_err k=%0d got=%b exp=%b", k, err_neg, err_m); end
`endif
      tick();
    end
    req_valid = '0;
    rsp_ready = '1;
    for (int k = 0; k < 30; k++) tick();
    settle();
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL rnd_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rsp_ready = '0;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      rand_ops(1'b0);
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 19; k++) tick();
    req_valid = '1;
    for (int k = 0; k < 4; k++) tick();
    req_valid = '0;
    settle();
    n_checks++; if (rsp_valid !== exp_valid) begin n_fail++; $display("FAIL mid_pre got=%b exp=%b", rsp_valid, exp_valid); end
    reset_l = 1'b0;
    #1;
    n_checks++; if (req_ready !== '0 || rsp_valid !== '0 || rsp_f !== '0) begin n_fail++; $display("FAIL mid_async got=%b/%b/%h exp=0/0/0", req_ready, rsp_valid, rsp_f); end
    @(posedge clk);
    @(negedge clk);
    reset_l = 1'b1;
    model_reset();
    rsp_ready = '1;
    for (int k = 0; k < 40; k++) begin
      settle();
      n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL mid_ghost k=%0d got=%b exp=0", k, rsp_valid); end
      tick();
    end
  endtask

  task automatic test_neg();
    bit found = 1'b0;
    logic [W-1:0] want;
`ifdef USQRT_ARB_NEG_CHECK_EN
    want = '0;
`else
    want = 20'h0B504;
`endif
    do_reset();
    rsp_ready = '1;
    req_a = '0;
    req_a[2*W +: W] = 20'h80000;
    req_valid = 4'b0100;
    settle();
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL neg_grant got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
`ifdef USQRT_ARB_NEG_CHECK_EN
    n_checks++; if (err_neg !== 4'b0100) begin n_fail++; $display("FAIL neg_flag got=%b exp=0100", err_neg); end
`endif
    for (int k = 0; k < 40 && !found; k++) begin
      settle();
      if (rsp_valid[2]) begin
        found = 1'b1;
        n_checks++; if (rsp_f[2*W +: W] !== want) begin n_fail++; $display("FAIL neg_f got=%h exp=%h", rsp_f[2*W +: W], want); end
      end
      tick();
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL neg_timeout got=no_result exp=result_within_40"); end
`ifdef USQRT_ARB_NEG_CHECK_EN
    n_checks++; if (err_neg !== 4'b0100) begin n_fail++; $display("FAIL neg_sticky got=%b exp=0100", err_neg); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_neg();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/usqrt_arb.md
Name: usqrt_arb

Overview:
- Shares one pipelined unsigned fixed-point square-root datapath (usqrt) among N independent requesters.
- Each requester owns a valid/ready request channel and a valid/ready response channel.
- A round-robin arbiter issues at most one operand per cycle into the non-stallable pipeline, and a tag pipe carries requester IDs alongside the operands.
- Per-requester result FIFOs with credit counting guarantee a result is never dropped when a consumer back-pressures.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 20, operand/result width, passed to the usqrt fixedp parameters.
- SCALE, 12, fraction bits, passed to usqrt.
- LAT, 16, cycle latency of the embedded usqrt instance. Must equal WIDTH-(WIDTH-SCALE)/2; an elaboration check fails otherwise.
- DEPTH, 4, per-requester result FIFO depth (power of 2, ≥1).

Ports:
- clk  input  1  single clock, all state on rising edge
- reset_l  input  1  asynchronous active-low reset
- req_valid  input  N  requester i has an operand
- req_ready  output  N  operand i accepted this cycle (one-hot or zero)
- req_a  input  N*WIDTH  operand i at bits [i*WIDTH +: WIDTH]
- rsp_valid  output  N  result available for requester i
- rsp_ready  input  N  consumer i takes result
- rsp_f  output  N*WIDTH  result i, FIFO head

Behaviour:
- Reset (async assert, sync release):
  - req_ready=0, rsp_valid=0, rsp_f=0.
  - Tag pipe valid bits=0, credit counters=0, FIFOs empty, RR pointer=0.
- Credits:
  - cnt[i] = in-flight ops for i + entries in FIFO i, range 0..DEPTH.
  - Requester i is eligible iff req_valid[i] && cnt[i] < DEPTH.
  - cnt[i] increments on grant to i and decrements on rsp_valid[i]&&rsp_ready[i]. Both in the same cycle leave it unchanged.
- Arbitration (combinational from registered state):
  - Search from ptr, ptr+1, …, wrapping mod N. The first eligible requester gets req_ready[i]=1; all others get 0.
  - On a grant, ptr <= winner+1 mod N. With no grant, ptr holds.
  - A requester with a full credit count is skipped and does not block the others.
- Issue:
  - The granted operand is registered into the issue register (a_q, vld_q, tag_q) at the accept edge. An idle cycle drives a_q=0, vld_q=0.
  - a_q feeds usqrt.a.
  - vld_q/tag_q enter a LAT-deep shift register aligned with usqrt.f.
  - The pipe never stalls.
- Writeback:
  - When the tag pipe output is valid, usqrt.f is written into FIFO[tag] at the next edge.
  - Credits guarantee FIFO[tag] is not full. An assertion flags the violation under simulation.
- Latency:
  - Accept at edge t; rsp_valid[i] rises after edge t+LAT+2 if FIFO i was empty.
  - Throughput is 1 result/cycle aggregate.
- FIFO:
  - rsp_valid[i] = FIFO i non-empty; rsp_f slice = head.
  - The head must hold stable while rsp_valid && !rsp_ready.
  - Simultaneous write and pop on a non-empty FIFO is allowed. On an empty FIFO, the written entry becomes the head next cycle; there is no fall-through.
- Ordering: results per requester return in acceptance order. There is no ordering guarantee across requesters.
- Reset mid-operation: all in-flight ops and buffered results are discarded. No response is produced for them after release.
- Width:
  - usqrt output f has LEFT/2 zero MSBs, where LEFT=WIDTH-SCALE.
  - The result is floor(sqrt(a/2^SCALE)·2^SCALE) as delivered by usqrt, unmodified.

Optional Feature:
- Macro: USQRT_ARB_NEG_CHECK_EN.
- Enabled:
  - Adds output err_neg[N]. Reset 0, sticky per requester.
  - Bit i is set when an operand with MSB=1 is accepted from i.
  - That operand is still issued, but its result is forced to 0 at FIFO write. The flag is carried in the tag pipe.
- Disabled: no port, no extra tag bit; MSB=1 operands pass through unchanged.

Test Plan:
- Single op: req 0, a=0x04000 (4.0), rsp_ready=1 → rsp_valid[0] at accept+18 cycles, rsp_f=0x02000; no other rsp_valid.
- Round-robin: all 4 req_valid held high with distinct operands, ptr=0 → grants 0,1,2,3,0,… one per cycle. Results 0x01000→0x01000 and 0x02000→0x016A0 land in the correct FIFOs.
- Back-pressure: rsp_ready[1]=0 while requester 1 streams → exactly DEPTH=4 accepts, then req_ready[1]=0. Others continue at full rate. Releasing rsp_ready drains 4 results in order, then accepts resume.
- Simultaneous pop+grant at cnt=DEPTH-1 → cnt unchanged, no overflow; assertion silent over 10k random cycles against the scoreboard floor(sqrt) model.
- Reset mid-flight: 8 ops in flight, pulse reset_l low 1 cycle → all outputs 0 immediately (async). No rsp_valid in the following 40 cycles without new requests.
- NEG_CHECK_EN: a=0x80000 on req 2 → err_neg[2]=1 from the next cycle and stays set; rsp_f=0. The build without the macro returns usqrt's raw result.
